// File: rtl/cache_arbiter.sv
// Arbitrates the single physical-memory line port between the I-cache (read-only) and the D-cache.
// One transaction at a time; the winner's request is latched and held until memory responds.
module cache_arbiter #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         icache_pmem_read,
    input  logic [15:0]  icache_pmem_address,
    output logic         icache_pmem_resp,
    output logic [127:0] icache_pmem_rdata,
    input  logic         dcache_pmem_read,
    input  logic         dcache_pmem_write,
    input  logic [15:0]  dcache_pmem_address,
    input  logic [127:0] dcache_pmem_wdata,
    output logic         dcache_pmem_resp,
    output logic [127:0] dcache_pmem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
);

    localparam int unsigned AW = 16;
    localparam int unsigned LW = 128;
    localparam logic [AW-1:0] LINE_MASK = ~AW'(15);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    logic [1:0]    r_state,      w_state_nxt;
    logic [AW-1:0] r_lat_addr,   w_lat_addr_nxt;
    logic [LW-1:0] r_lat_wdata,  w_lat_wdata_nxt;
    logic          r_lat_write,  w_lat_write_nxt;
    logic          r_pmem_read,  w_pmem_read_nxt;
    logic          r_last_grant, w_last_grant_nxt;

    logic w_i_req;
    logic w_d_req;
    logic w_d_wins;

    assign w_i_req  = icache_pmem_read;
    assign w_d_req  = dcache_pmem_read | dcache_pmem_write;
    // On a tie the D-cache wins unless round-robin says it was served last.
    assign w_d_wins = w_d_req & (~w_i_req | ~ROUND_ROBIN | ~r_last_grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lat_addr   <= '0;
            r_lat_wdata  <= '0;
            r_lat_write  <= 1'b0;
            r_pmem_read  <= 1'b0;
            r_last_grant <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lat_addr   <= w_lat_addr_nxt;
            r_lat_wdata  <= w_lat_wdata_nxt;
            r_lat_write  <= w_lat_write_nxt;
            r_pmem_read  <= w_pmem_read_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Next-state and latch loading; latched values clear on return to IDLE so the port idles at zero.
    always_comb begin
        w_state_nxt      = r_state;
        w_lat_addr_nxt   = r_lat_addr;
        w_lat_wdata_nxt  = r_lat_wdata;
        w_lat_write_nxt  = r_lat_write;
        w_pmem_read_nxt  = r_pmem_read;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            IDLE: begin
                if (w_d_wins) begin
                    w_state_nxt      = GRANT_D;
                    w_lat_addr_nxt   = dcache_pmem_address & LINE_MASK;
                    w_lat_wdata_nxt  = dcache_pmem_wdata;
                    w_lat_write_nxt  = dcache_pmem_write;
                    w_pmem_read_nxt  = ~dcache_pmem_write;
                    w_last_grant_nxt = 1'b1;
                end else if (w_i_req) begin
                    w_state_nxt      = GRANT_I;
                    w_lat_addr_nxt   = icache_pmem_address & LINE_MASK;
                    w_lat_wdata_nxt  = '0;
                    w_lat_write_nxt  = 1'b0;
                    w_pmem_read_nxt  = 1'b1;
                    w_last_grant_nxt = 1'b0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (pmem_resp) begin
                    w_state_nxt     = IDLE;
                    w_lat_addr_nxt  = '0;
                    w_lat_wdata_nxt = '0;
                    w_lat_write_nxt = 1'b0;
                    w_pmem_read_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_lat_addr_nxt  = '0;
                w_lat_wdata_nxt = '0;
                w_lat_write_nxt = 1'b0;
                w_pmem_read_nxt = 1'b0;
            end
        endcase
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_lat_write;
    assign pmem_address = r_lat_addr;
    assign pmem_wdata   = r_lat_wdata;

    // Completion is steered combinationally to whichever cache holds the grant.
    assign icache_pmem_resp  = (r_state == GRANT_I) & pmem_resp;
    assign dcache_pmem_resp  = (r_state == GRANT_D) & pmem_resp;
    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
Shares the single physical-memory line port (128-bit line, 16-bit address) between the instruction cache and the data cache. Sits between the two caches' pmem sides and physical memory. The I-cache is read-only; the D-cache issues both line reads (fills) and line writes (writebacks). One transaction is in flight at a time. The arbiter latches the winning request and sequences it to physical memory until that memory returns `pmem_resp`.

Parameters:
- ROUND_ROBIN, 0: 0 = fixed priority, D-cache wins ties. 1 = on a tie, grant the requester not granted most recently.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- icache_pmem_read  in  1  I-cache line read request; held until icache_pmem_resp
- icache_pmem_address  in  16  I-cache line address
- icache_pmem_resp  out  1  one-cycle completion pulse to I-cache
- icache_pmem_rdata  out  128  read line to I-cache
- dcache_pmem_read  in  1  D-cache line read request
- dcache_pmem_write  in  1  D-cache line write request
- dcache_pmem_address  in  16  D-cache line address
- dcache_pmem_wdata  in  128  D-cache writeback line
- dcache_pmem_resp  out  1  one-cycle completion pulse to D-cache
- dcache_pmem_rdata  out  128  read line to D-cache
- pmem_read  out  1  read request to physical memory
- pmem_write  out  1  write request to physical memory
- pmem_address  out  16  line address to memory; bits [3:0] always 0
- pmem_wdata  out  128  write line to memory
- pmem_resp  in  1  memory completion, one cycle
- pmem_rdata  in  128  memory read line, valid with pmem_resp

Behaviour:
- State machine: IDLE, GRANT_I, GRANT_D.
- Internal registers:
  - lat_addr[15:0], lat_wdata[127:0], lat_write
  - last_grant (0 = I, 1 = D)
- Reset (synchronous): state goes to IDLE; latched registers clear to 0; last_grant = 0.
- Output values at reset and in IDLE:
  - pmem_read = pmem_write = 0
  - pmem_address = 0, pmem_wdata = 0
  - both resp = 0
- IDLE transitions:
  - Only I request pending: latch icache address with [3:0] forced to 0, set lat_write = 0, go to GRANT_I.
  - Only D request (read or write) pending: latch dcache address (low nibble zeroed), wdata, and lat_write = dcache_pmem_write, go to GRANT_D.
  - Both pending, ROUND_ROBIN=0: go to GRANT_D.
  - Both pending, ROUND_ROBIN=1: go to GRANT_I if last_grant = 1, otherwise GRANT_D.
  - Update last_grant on every grant.
- GRANT_x state:
  - pmem_read = ~lat_write, pmem_write = lat_write.
  - pmem_address = lat_addr, pmem_wdata = lat_wdata. All outputs are driven from registers only, with no combinational path from cache inputs.
  - On pmem_resp: assert resp only to the granted cache in the same cycle (combinational from pmem_resp). The other cache's resp stays 0. Return to IDLE.
- rdata: icache_pmem_rdata and dcache_pmem_rdata both equal pmem_rdata at all times. Only the resp pulse qualifies them.
- Latency:
  - Request to pmem_read/pmem_write asserted: 1 cycle.
  - pmem_resp to cache resp: 0 cycles.
  - Minimum turnaround between back-to-back grants: one IDLE cycle. The requester drops its request the cycle after resp, so it is not regranted.
- Simultaneous dcache read and write both high: treated as write, lat_write = 1.
- Request inputs change or drop while granted: ignored. The latched values are used until pmem_resp.
- pmem_resp while in IDLE: ignored. No resp to either cache, state unchanged.
- Reset asserted mid-transaction: next cycle is IDLE with pmem_read/pmem_write = 0. A pmem_resp arriving later is discarded. No resp pulse goes to either cache.
- No starvation with ROUND_ROBIN=1. With 0, the I-cache can starve under continuous D traffic; this is accepted.

Test Plan:
- I-only read at address 0x1234: pmem_read = 1 with pmem_address = 0x1230 one cycle later. Memory resp after 3 cycles with rdata = 0xA5..A5 gives icache_pmem_resp = 1 and icache_pmem_rdata = 0xA5..A5 in that cycle. dcache_pmem_resp stays 0.
- D write at address 0x8008 with wdata = 0xDEAD_BEEF repeated: pmem_write = 1, pmem_address = 0x8000, wdata matches. The D-cache changes its address to 0x0000 during the grant, and pmem_address stays 0x8000 until resp.
- Simultaneous I read 0x0100 and D read 0x0200, ROUND_ROBIN=0: the D grant is served first, then one IDLE cycle, then the I grant at 0x0100.
- ROUND_ROBIN=1 with both requesting continuously for 4 transactions: grant order D, I, D, I. Each resp goes only to the granted cache.
- Reset pulsed for one cycle two cycles into a D grant, with a pmem_resp arriving after reset: pmem_read drops the cycle after reset. No resp pulse to either cache. Next request is granted normally.
- Stray pmem_resp in IDLE and dcache read+write both high at address 0x4000: no resp output from the stray. The next grant issues pmem_write = 1, pmem_read = 0.
